ecp5_phase_stepper: RTL

- Sequencer that drives the ecp5pll dynamic phase-adjust inputs: phasesel, phasedir, phasestep and phaseloadreg.
- Sits directly upstream of the PLL in the clock subsystem.
- Accepts a request of the form "shift output N by S signed fine steps" over a valid/ready handshake.
- Emits S correctly timed phasestep pulses, then signals completion. Used for DDR/SDRAM and video clock alignment.

---
 rtl/ecp5_phase_stepper_if.sv | 30 +++
 rtl/ecp5_phase_stepper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ecp5_phase_stepper_if.sv
// rtl/ecp5_phase_stepper_if.sv - request handshake bundle for ecp5_phase_stepper
//
// Purpose: carries one "shift PLL output N by S signed fine steps" request.
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  stepper can accept a request
//   req_sel    master->slave  PLL output index 0..3
//   req_steps  master->slave  signed step count (positive = delay, negative = advance)
interface ecp5_phase_stepper_if #(
  parameter int STEP_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic [STEP_W-1:0] req_steps;

  modport master (
    output req_valid,
    output req_sel,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    input  req_steps,
    output req_ready
  );
endinterface

// File: rtl/ecp5_phase_stepper.sv
// rtl/ecp5_phase_stepper.sv - ECP5 PLL dynamic phase-adjust sequencer
//
// Purpose: accepts a signed fine-step request and drives the ecp5pll
// phasesel/phasedir/phasestep/phaseloadreg inputs with correctly timed
// phasestep pulses, then emits a one-cycle done pulse.
//
// Optional feature macro: ECP5_PHASE_STEPPER_TRACK_EN
//   When defined, four signed STEP_W+4 bit accumulators phase_acc0..3 track
//   the net number of steps applied to each PLL output.
//
// Ports:
//   clk_i         system clock
//   reset_n       asynchronous active-low reset
//   locked        PLL lock indication; GAP timing freezes while low
//   req           request handshake (slave side of ecp5_phase_stepper_if)
//   busy          sequence in progress (SETUP/PULSE/GAP/DONE)
//   done          one-cycle completion pulse
//   phasesel      PLL output select, stable while busy
//   phasedir      0 = delay, 1 = advance, stable while busy
//   phasestep     active-high step pulse to the PLL
//   phaseloadreg  held low (registered)
//   phase_acc0..3 per-output step accumulators (TRACK_EN only)
module ecp5_phase_stepper #(
  parameter int STEP_W       = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic                     locked,
  ecp5_phase_stepper_if.slave      req,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               phasesel,
  output logic                     phasedir,
  output logic                     phasestep,
  output logic                     phaseloadreg
`ifdef ECP5_PHASE_STEPPER_TRACK_EN
  ,
  output logic signed [STEP_W+3:0] phase_acc0,
  output logic signed [STEP_W+3:0] phase_acc1,
  output logic signed [STEP_W+3:0] phase_acc2,
  output logic signed [STEP_W+3:0] phase_acc3
`endif
);

  localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              busy_q, done_q, step_q, loadreg_q;

  logic              accept;
  logic [STEP_W-1:0] req_mag;

  // Two's-complement magnitude in STEP_W unsigned bits: the most negative
  // value maps onto 2^(STEP_W-1), which still fits without overflow.
  assign req_mag = req.req_steps[STEP_W-1] ? ((~req.req_steps) + STEP_W'(1))
                                           : req.req_steps;

  assign req.req_ready = (state_q == IDLE) && locked && reset_n;
  assign accept        = req.req_valid && req.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d   = req.req_sel;
          dir_d   = req.req_steps[STEP_W-1];
          rem_d   = req_mag;
          cnt_d   = '0;
          state_d = (req_mag == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PULSE: begin
        // A started pulse always runs to full width, locked or not.
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          rem_d   = rem_q - STEP_W'(1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        // Gap time only counts while the PLL is locked.
        if (locked) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = (rem_q == '0) ? DONE : PULSE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      sel_q     <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= 1'b0;
      loadreg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      step_q    <= (state_d == PULSE);
      loadreg_q <= 1'b0;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = loadreg_q;

`ifdef ECP5_PHASE_STEPPER_TRACK_EN
  localparam int ACC_W = STEP_W + 4;

  logic [ACC_W-1:0] acc_q [4];
  logic             pulse_entry;

  // sel_q/dir_q are already the captured request values on every PULSE entry.
  assign pulse_entry = (state_q != PULSE) && (state_d == PULSE);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
    end else if (pulse_entry) begin
      acc_q[sel_q] <= dir_q ? (acc_q[sel_q] - ACC_W'(1))
                            : (acc_q[sel_q] + ACC_W'(1));
    end
  end

  assign phase_acc0 = acc_q[0];
  assign phase_acc1 = acc_q[1];
  assign phase_acc2 = acc_q[2];
  assign phase_acc3 = acc_q[3];
`endif

endmodule
